// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Memory-stage load/store sequencer in front of dmem. Takes one scalar or vector request
//   over a valid/ready handshake, drives dmem port A (scalar) or port B (vector), and returns
//   each load result or store completion over a valid/ready response handshake.
//   Vectors with stride 1 use a single port-B access; any other stride (including 0) is
//   split into LANES port-A accesses (gather/scatter).
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       request handshake; req_ready only while idle and not in reset
//   req_we, req_vec           store/load, vector/scalar
//   req_addr, req_stride      base element address, vector element stride
//   req_wdata                 store data (scalar uses the low DATA_W bits)
//   resp_valid/resp_ready     response handshake
//   resp_rdata                load result (zero for stores)
//   mem_*                     dmem command outputs and read data inputs
module dmem_access_unit #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LANES  = 16,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic                    req_vec,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [ADDR_W-1:0]       req_stride,
   input  logic [LANES*DATA_W-1:0] req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [LANES*DATA_W-1:0] resp_rdata,
   output logic                    mem_w_enable,
   output logic                    mem_src_sel,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_w_data_a,
   output logic [LANES*DATA_W-1:0] mem_w_data_b,
   input  logic [DATA_W-1:0]       mem_q_a,
   input  logic [LANES*DATA_W-1:0] mem_q_b
);

   localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);
   localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

   state_e              state_q;
   logic                we_q;
   logic                vec_q;
   logic                strided_q;
   logic [ADDR_W-1:0]   stride_q;
   logic [LIDX_W-1:0]   lane_q;
   logic [WCNT_W-1:0]   wait_q;
   logic [LIDX_W-1:0]   lane_nxt;
   logic                more_lanes;

   assign req_ready  = (state_q == StIdle) & ~rst;
   assign lane_nxt   = lane_q + LIDX_W'(1);
   assign more_lanes = strided_q & (lane_q != LAST_LANE);

   // mem_addr always holds the address of the lane currently being accessed; the next lane's
   // address is derived from it, so base + i*stride wraps naturally at 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         vec_q        <= 1'b0;
         strided_q    <= 1'b0;
         stride_q     <= '0;
         lane_q       <= '0;
         wait_q       <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         mem_w_enable <= 1'b0;
         mem_src_sel  <= 1'b0;
         mem_addr     <= '0;
         mem_w_data_a <= '0;
         mem_w_data_b <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q         <= req_we;
                  vec_q        <= req_vec;
                  strided_q    <= req_vec & (req_stride != ADDR_W'(1));
                  stride_q     <= req_stride;
                  lane_q       <= '0;
                  wait_q       <= '0;
                  resp_rdata   <= '0;
                  mem_w_enable <= req_we;
                  mem_src_sel  <= req_vec & (req_stride == ADDR_W'(1));
                  mem_addr     <= req_addr;
                  mem_w_data_a <= req_wdata[DATA_W-1:0];
                  mem_w_data_b <= req_wdata;
                  state_q      <= StAccess;
               end
            end

            StAccess: begin
               if (we_q && more_lanes) begin
                  // Strided store: one lane per cycle, write enable held high throughout.
                  lane_q       <= lane_nxt;
                  mem_addr     <= mem_addr + stride_q;
                  mem_w_data_a <= mem_w_data_b[lane_nxt*DATA_W +: DATA_W];
               end else if (we_q) begin
                  mem_w_enable <= 1'b0;
                  resp_valid   <= 1'b1;
                  state_q      <= StResp;
               end else begin
                  wait_q  <= '0;
                  state_q <= StWait;
               end
            end

            StWait: begin
               if (wait_q != LAST_WAIT) begin
                  wait_q <= wait_q + WCNT_W'(1);
               end else begin
                  if (vec_q && !strided_q) begin
                     resp_rdata <= mem_q_b;
                  end else begin
                     resp_rdata[lane_q*DATA_W +: DATA_W] <= mem_q_a;
                  end
                  if (more_lanes) begin
                     lane_q   <= lane_nxt;
                     mem_addr <= mem_addr + stride_q;
                     state_q  <= StAccess;
                  end else begin
                     resp_valid <= 1'b1;
                     state_q    <= StResp;
                  end
               end
            end

            StResp: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state_q    <= StIdle;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit
//   Bench for dmem_access_unit with a behavioural dmem (1-cycle read latency, read-before-write).
//   Expected responses come from a reference memory updated as requests are issued; they are
//   queued at issue and compared, together with response latency, when resp_valid rises.
module tb_dmem_access_unit;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_we = 1'b0;
   logic         req_vec = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [31:0]  req_stride = '0;
   logic [255:0] req_wdata = '0;
   logic         resp_valid;
   logic         resp_ready = 1'b1;
   logic [255:0] resp_rdata;
   logic         mem_w_enable;
   logic         mem_src_sel;
   logic [31:0]  mem_addr;
   logic [15:0]  mem_w_data_a;
   logic [255:0] mem_w_data_b;
   logic [15:0]  mem_q_a;
   logic [255:0] mem_q_b;

   dmem_access_unit #(
      .DATA_W (16),
      .LANES  (16),
      .ADDR_W (32),
      .RD_LAT (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_vec      (req_vec),
      .req_addr     (req_addr),
      .req_stride   (req_stride),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .mem_w_enable (mem_w_enable),
      .mem_src_sel  (mem_src_sel),
      .mem_addr     (mem_addr),
      .mem_w_data_a (mem_w_data_a),
      .mem_w_data_b (mem_w_data_b),
      .mem_q_a      (mem_q_a),
      .mem_q_b      (mem_q_b)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   // Behavioural dmem.
   logic [15:0] dmem [bit [31:0]];
   int wr_a = 0;
   int wr_b = 0;

   function automatic logic [15:0] dmem_rd(input logic [31:0] a);
      return dmem.exists(a) ? dmem[a] : 16'h0;
   endfunction

   always @(posedge clk) begin
      logic [255:0] qb;
      for (int i = 0; i < 16; i++) qb[i*16 +: 16] = dmem_rd(mem_addr + 32'(i));
      mem_q_a <= dmem_rd(mem_addr);
      mem_q_b <= qb;
      if (mem_w_enable) begin
         if (mem_src_sel) begin
            for (int i = 0; i < 16; i++) dmem[mem_addr + 32'(i)] = mem_w_data_b[i*16 +: 16];
            wr_b = wr_b + 1;
         end else begin
            dmem[mem_addr] = mem_w_data_a;
            wr_a = wr_a + 1;
         end
      end
   end

   // Reference memory and scoreboard.
   logic [15:0] ref_mem [bit [31:0]];

   function automatic logic [15:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
   endfunction

   typedef struct {
      logic [255:0] rdata;
      int           acc;
      int           lat;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] lanes(input logic [15:0] base, input bit inc);
      logic [255:0] v;
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = inc ? base + 16'(i) : base;
      return v;
   endfunction

   // Issue one request; apply_lanes limits how many store lanes the reference memory sees.
   task automatic send(input bit we, input bit vec, input logic [31:0] addr,
                       input logic [31:0] stride, input logic [255:0] wdata,
                       input bit expect_resp, input int apply_lanes);
      exp_t e;
      int   n;
      bit   strided;
      strided = vec && (stride != 32'd1);
      e.rdata = '0;
      if (we) begin
         if (!vec) ref_mem[addr] = wdata[15:0];
         else for (int i = 0; i < apply_lanes; i++) ref_mem[addr + 32'(i) * stride] = wdata[i*16 +: 16];
         e.lat = strided ? 16 : 1;
      end else begin
         if (!vec) e.rdata[15:0] = ref_rd(addr);
         else for (int i = 0; i < 16; i++) e.rdata[i*16 +: 16] = ref_rd(addr + 32'(i) * stride);
         e.lat = strided ? 32 : 2;
      end
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_at_issue", 256'(req_ready), 256'(1));
      req_valid  = 1'b1;
      req_we     = we;
      req_vec    = vec;
      req_addr   = addr;
      req_stride = stride;
      req_wdata  = wdata;
      e.acc      = edges + 1;
      if (expect_resp) exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 256'(exp_q.size()), 256'(0));
   endtask

   // Response monitor: compares on the first cycle of each response.
   initial begin : monitor
      bit   was_valid;
      exp_t item;
      was_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_valid && !was_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 256'(resp_valid), 256'(0));
            end else begin
               item = exp_q.pop_front();
               chk("resp_latency", 256'(edges - item.acc), 256'(item.lat));
               chk("resp_rdata", resp_rdata, item.rdata);
            end
         end
         was_valid = resp_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d responses still pending", exp_q.size());
      $fatal(1);
   end

   initial begin : main
      int a0;
      int b0;
      int n;
      logic [255:0] hold_exp;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_resp_valid", 256'(resp_valid), 256'(0));
      chk("rst_resp_rdata", resp_rdata, 256'(0));
      chk("rst_w_enable", 256'(mem_w_enable), 256'(0));
      chk("rst_src_sel", 256'(mem_src_sel), 256'(0));
      chk("rst_mem_addr", 256'(mem_addr), 256'(0));
      chk("rst_req_ready", 256'(req_ready), 256'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("req_ready_after_rst", 256'(req_ready), 256'(1));

      // 1: scalar store then load.
      a0 = wr_a; b0 = wr_b;
      send(1'b1, 1'b0, 32'h10, 32'd0, 256'hFFFF, 1'b1, 16);
      drain();
      chk("t1_wr_a", 256'(wr_a - a0), 256'(1));
      chk("t1_wr_b", 256'(wr_b - b0), 256'(0));
      send(1'b0, 1'b0, 32'h10, 32'd0, '0, 1'b1, 16);
      drain();

      // 2: contiguous vector store then load.
      a0 = wr_a; b0 = wr_b;
      send(1'b1, 1'b1, 32'h20, 32'd1, lanes(16'hAAAA, 1'b0), 1'b1, 16);
      drain();
      chk("t2_wr_b", 256'(wr_b - b0), 256'(1));
      chk("t2_wr_a", 256'(wr_a - a0), 256'(0));
      send(1'b0, 1'b1, 32'h20, 32'd1, '0, 1'b1, 16);
      drain();

      // 3: gather with stride 4 (preloaded by a scatter).
      a0 = wr_a;
      send(1'b1, 1'b1, 32'h100, 32'd4, lanes(16'h0, 1'b1), 1'b1, 16);
      drain();
      chk("t3_wr_a", 256'(wr_a - a0), 256'(16));
      send(1'b0, 1'b1, 32'h100, 32'd4, '0, 1'b1, 16);
      drain();

      // 4: stride-2 scatter, contiguous readback.
      send(1'b1, 1'b1, 32'h200, 32'd2, lanes(16'h1000, 1'b1), 1'b1, 16);
      send(1'b0, 1'b1, 32'h200, 32'd1, '0, 1'b1, 16);
      drain();

      // Stride 0: last lane wins; stride-0 load replicates one element.
      send(1'b1, 1'b1, 32'h400, 32'd0, lanes(16'h5000, 1'b1), 1'b1, 16);
      send(1'b0, 1'b0, 32'h400, 32'd0, '0, 1'b1, 16);
      send(1'b0, 1'b1, 32'h400, 32'd0, '0, 1'b1, 16);
      drain();

      // 5: address wrap, then a held response.
      send(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd1, lanes(16'h6000, 1'b1), 1'b1, 16);
      send(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd2, lanes(16'h7000, 1'b1), 1'b1, 16);
      send(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd1, '0, 1'b1, 16);
      drain();
      resp_ready = 1'b0;
      hold_exp   = 256'(ref_rd(32'h0));
      send(1'b0, 1'b0, 32'h0, 32'd0, '0, 1'b1, 16);
      for (n = 0; n < 50 && !resp_valid; n++) @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_vec   = 1'b0;
      req_addr  = 32'h10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_resp_valid", 256'(resp_valid), 256'(1));
         chk("hold_resp_rdata", resp_rdata, hold_exp);
         chk("hold_req_ready", 256'(req_ready), 256'(0));
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      drain();

      // 6: reset during lane 5 of a stride-3 scatter.
      send(1'b1, 1'b1, 32'h300, 32'd3, lanes(16'h3000, 1'b1), 1'b1, 16);
      drain();
      a0 = wr_a;
      send(1'b1, 1'b1, 32'h300, 32'd3, lanes(16'hB000, 1'b1), 1'b0, 6);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_w_enable", 256'(mem_w_enable), 256'(0));
      chk("abort_resp_valid", 256'(resp_valid), 256'(0));
      chk("abort_req_ready", 256'(req_ready), 256'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("abort_req_ready_after", 256'(req_ready), 256'(1));
      chk("abort_wr_a", 256'(wr_a - a0), 256'(6));
      for (int i = 6; i < 16; i++) begin
         chk("abort_lane_untouched", 256'(dmem_rd(32'h300 + 32'(i * 3))), 256'(16'h3000 + 16'(i)));
      end
      send(1'b0, 1'b1, 32'h300, 32'd3, '0, 1'b1, 16);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
